led_serializer: RTL

Parallel-to-serial shifter that drives the board's external LED shift-register chain. It sits directly downstream of the GPIO output register: it captures the 16-bit LED word (already inverted upstream for active-low LEDs) on a Start edge. It then shifts the word out on a divided serial clock with a pre-clear, and pulses a latch enable when the frame is complete. Frames are fixed length and non-overlapping.

---
 rtl/led_serializer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/led_serializer.sv
// Parallel-to-serial driver for the external LED shift-register chain: pre-clear, 2-cycle bits, latch pulse.
// Optional build macro LED_SERIALIZER_REQUEUE_EN queues one Start edge that arrives while a frame is in flight.
module led_serializer #(
    parameter int DATA_BITS       = 16,
    parameter int DATA_COUNT_BITS = 4,
    parameter bit DIR             = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Start,
    input  logic [DATA_BITS-1:0] PData,
    output logic                 sclk,
    output logic                 sout,
    output logic                 sclrn,
    output logic                 EN,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, LATCH} state_t;

    localparam logic [DATA_COUNT_BITS-1:0] LAST_BIT = DATA_COUNT_BITS'(DATA_BITS - 1);

    state_t                     state, state_nxt;
    logic                       phase, phase_nxt;
    logic [DATA_COUNT_BITS-1:0] cnt, cnt_nxt;
    logic [DATA_BITS-1:0]       shift_reg, shift_nxt;
    logic                       start_d;
    logic                       start_edge;
    logic                       sout_nxt;

`ifdef LED_SERIALIZER_REQUEUE_EN
    logic                 pend, pend_nxt;
    logic [DATA_BITS-1:0] pend_data;
`endif

    function automatic logic head_bit(input logic [DATA_BITS-1:0] w);
        return DIR ? w[0] : w[DATA_BITS-1];
    endfunction

    function automatic logic [DATA_BITS-1:0] shift_one(input logic [DATA_BITS-1:0] w);
        return DIR ? (w >> 1) : (w << 1);
    endfunction

    assign start_edge = Start & ~start_d;

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        cnt_nxt   = cnt;
        shift_nxt = shift_reg;
`ifdef LED_SERIALIZER_REQUEUE_EN
        pend_nxt  = pend;
        if (start_edge && state != IDLE && state != LATCH)
            pend_nxt = 1'b1;
`endif
        case (state)
            IDLE: begin
                if (start_edge) begin
                    shift_nxt = PData;
                    cnt_nxt   = '0;
                    phase_nxt = 1'b0;
                    state_nxt = CLEAR;
                end
            end
            CLEAR: state_nxt = SHIFT;
            SHIFT: begin
                if (!phase) begin
                    phase_nxt = 1'b1;
                end else begin
                    // Shift on the edge that ends sclk high so the next bit is presented at phase 0.
                    shift_nxt = shift_one(shift_reg);
                    phase_nxt = 1'b0;
                    if (cnt == LAST_BIT)
                        state_nxt = LATCH;
                    else
                        cnt_nxt = cnt + DATA_COUNT_BITS'(1);
                end
            end
            LATCH: begin
                state_nxt = IDLE;
`ifdef LED_SERIALIZER_REQUEUE_EN
                if (pend || start_edge) begin
                    shift_nxt = start_edge ? PData : pend_data;
                    cnt_nxt   = '0;
                    phase_nxt = 1'b0;
                    pend_nxt  = 1'b0;
                    state_nxt = CLEAR;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next-state view so they line up with the state they describe.
    assign sout_nxt = (state_nxt == SHIFT && !phase_nxt) ? head_bit(shift_nxt) : sout;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            phase     <= 1'b0;
            cnt       <= '0;
            shift_reg <= '0;
            start_d   <= 1'b0;
            sclk      <= 1'b0;
            sout      <= 1'b0;
            sclrn     <= 1'b1;
            EN        <= 1'b0;
            busy      <= 1'b0;
`ifdef LED_SERIALIZER_REQUEUE_EN
            pend      <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            phase     <= phase_nxt;
            cnt       <= cnt_nxt;
            shift_reg <= shift_nxt;
            start_d   <= Start;
            sclk      <= (state_nxt == SHIFT) && phase_nxt;
            sout      <= sout_nxt;
            sclrn     <= (state_nxt != CLEAR);
            EN        <= (state_nxt == LATCH);
            busy      <= (state_nxt != IDLE);
`ifdef LED_SERIALIZER_REQUEUE_EN
            pend      <= pend_nxt;
`endif
        end
    end

`ifdef LED_SERIALIZER_REQUEUE_EN
    // Newest word wins when several edges land during one frame.
    always_ff @(posedge clk) begin
        if (start_edge && state != IDLE)
            pend_data <= PData;
    end
`endif

endmodule
